// File: rtl/alu_seq.sv
// alu_seq: handshaked execute-stage ALU with registered single-cycle ops and an iterative mul/div engine.
// Build option: define ALU_MULDIV_EN to build the MUL/DIVU/REMU engine; otherwise those codes return 0 in one cycle.
module alu_seq #(
  parameter  int WIDTH = 16,
  localparam int CNTW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic [3:0]       Op,
  input  logic             invA,
  input  logic             invB,
  input  logic             sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             Ofl,
  output logic             zero,
  output logic             div0
);

  // state | meaning
  // IDLE  | waiting for an operation
  // BUSY  | mul/div engine stepping, one iteration per cycle
  // DONE  | result held on Out until out_ready
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [3:0] OP_ROL = 4'h0, OP_ROR = 4'h1, OP_SLL = 4'h2, OP_SRA = 4'h3,
                         OP_SRL = 4'h4, OP_MUL = 4'h5, OP_DIVU = 4'h6, OP_REMU = 4'h7,
                         OP_ADD = 4'h8, OP_OR = 4'h9, OP_XOR = 4'hA, OP_AND = 4'hB,
                         OP_SCO = 4'hC, OP_SLE = 4'hD, OP_SLT = 4'hE, OP_SEQ = 4'hF;

  state_t           state, state_n;
  logic             accept, is_multi, last_step;
  logic [WIDTH-1:0] a, b, sc_res, eng_res, out_r;
  logic [CNTW-1:0]  sh;
  logic [WIDTH:0]   sum;
  logic             add_ovf, sc_ofl, eng_div0, ofl_r, div0_r;

  assign a  = invA ? ~A : A;
  assign b  = invB ? ~B : B;
  assign sh = b[CNTW-1:0];

  always_comb begin
    sum     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, Cin};
    add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    sc_res  = '0;
    sc_ofl  = 1'b0;
    case (Op)
      OP_ROL:  sc_res = (a << sh) | (a >> (WIDTH - int'(sh)));
      OP_ROR:  sc_res = (a >> sh) | (a << (WIDTH - int'(sh)));
      OP_SLL:  sc_res = a << sh;
      OP_SRA:  sc_res = $unsigned($signed(a) >>> sh);
      OP_SRL:  sc_res = a >> sh;
      OP_ADD: begin
        sc_res = sum[WIDTH-1:0];
        sc_ofl = sign ? add_ovf : sum[WIDTH];
      end
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_AND:  sc_res = a & b;
      OP_SCO:  sc_res[0] = sum[WIDTH];
      OP_SLE:  sc_res[0] = sign ? ($signed(a) <= $signed(b)) : (a <= b);
      OP_SLT:  sc_res[0] = sign ? ($signed(a) < $signed(b)) : (a < b);
      OP_SEQ:  sc_res[0] = (a == b);
      default: sc_res = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  // MUL reuses eng_a as shifting multiplicand, eng_b as multiplier, eng_acc as product.
  // DIVU/REMU reuse eng_a as dividend/quotient shifter, eng_b as divisor, eng_acc as remainder.
  logic [WIDTH-1:0] eng_a, eng_b, eng_acc, mul_acc_n, quo_n, rem_n, rem_sub;
  logic [WIDTH:0]   rem_sh;
  logic [1:0]       eng_op;
  logic [CNTW-1:0]  cnt;
  logic             q_bit, eng_bz;

  assign is_multi = (Op == OP_MUL) || (Op == OP_DIVU) || (Op == OP_REMU);

  always_comb begin
    mul_acc_n = eng_acc + (eng_b[0] ? eng_a : '0);
    rem_sh    = {eng_acc, eng_a[WIDTH-1]};
    q_bit     = rem_sh >= {1'b0, eng_b};
    rem_sub   = rem_sh[WIDTH-1:0] - eng_b;
    rem_n     = q_bit ? rem_sub : rem_sh[WIDTH-1:0];
    quo_n     = {eng_a[WIDTH-2:0], q_bit};
    case (eng_op)
      2'b01:   eng_res = mul_acc_n;
      2'b10:   eng_res = quo_n;
      default: eng_res = rem_n;
    endcase
  end

  assign last_step = (cnt == CNTW'(WIDTH - 1));
  // a zero divisor naturally yields all-ones quotient and remainder = a; only the flag is extra
  assign eng_div0  = eng_bz & eng_op[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_a   <= '0;
      eng_b   <= '0;
      eng_acc <= '0;
      eng_op  <= '0;
      eng_bz  <= 1'b0;
      cnt     <= '0;
    end else if (accept && is_multi) begin
      eng_a   <= a;
      eng_b   <= b;
      eng_acc <= '0;
      eng_op  <= Op[1:0];
      eng_bz  <= (b == '0);
      cnt     <= '0;
    end else if (state == S_BUSY) begin
      cnt <= cnt + CNTW'(1);
      if (eng_op == 2'b01) begin
        eng_acc <= mul_acc_n;
        eng_a   <= eng_a << 1;
        eng_b   <= eng_b >> 1;
      end else begin
        eng_acc <= rem_n;
        eng_a   <= quo_n;
      end
    end
  end
`else
  assign is_multi  = 1'b0;
  assign eng_res   = '0;
  assign last_step = 1'b1;
  assign eng_div0  = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: in_ready = 1'b1;
      S_BUSY: if (last_step) state_n = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    accept = in_valid & in_ready;
    if (accept) state_n = is_multi ? S_BUSY : S_DONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      out_r  <= '0;
      ofl_r  <= 1'b0;
      div0_r <= 1'b0;
    end else begin
      state <= state_n;
      if (accept && !is_multi) begin
        out_r  <= sc_res;
        ofl_r  <= sc_ofl;
        div0_r <= 1'b0;
      end else if (state == S_BUSY && last_step) begin
        out_r  <= eng_res;
        ofl_r  <= 1'b0;
        div0_r <= eng_div0;
      end
    end
  end

  assign Out  = out_r;
  assign Ofl  = ofl_r;
  assign zero = (out_r == '0);
  assign div0 = div0_r;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed spec cases, busy/back-pressure/reset scenarios and random ops vs a reference model.
module tb_alu_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, Cin, invA, invB, sign;
  logic         out_valid, out_ready, Ofl, zero, div0;
  logic [W-1:0] A, B, Out;
  logic [3:0]   Op;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] got_out;
  logic         got_ofl, got_zero, got_div0;
  int           got_lat;
  bit           busy_ok;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .Op(Op), .invA(invA), .invB(invB), .sign(sign),
    .out_valid(out_valid), .out_ready(out_ready), .Out(Out), .Ofl(Ofl),
    .zero(zero), .div0(div0)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: results from plain integer arithmetic on the operand values.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a_in, b_in,
                                input bit cin, sg, ia, ib,
                                output logic [W-1:0] r, output bit o, output bit dz,
                                output int lat);
    logic [W-1:0] a, b;
    int unsigned  ua, ub, s;
    int           sa, sb, ss, sh;
    a  = ia ? ~a_in : a_in;
    b  = ib ? ~b_in : b_in;
    ua = a;
    ub = b;
    sa = $signed(a);
    sb = $signed(b);
    sh = int'(ub % W);
    s  = ua + ub + int'(cin);
    ss = sa + sb + int'(cin);
    r = '0; o = 1'b0; dz = 1'b0; lat = 1;
    case (op)
      4'h0: begin r = a; repeat (sh) r = {r[W-2:0], r[W-1]}; end
      4'h1: begin r = a; repeat (sh) r = {r[0], r[W-1:1]}; end
      4'h2: r = W'(ua << sh);
      4'h3: r = W'(sa >>> sh);
      4'h4: r = W'(ua >> sh);
`ifdef ALU_MULDIV_EN
      4'h5: begin r = W'(ua * ub); lat = W + 1; end
      4'h6: begin
        lat = W + 1;
        if (ub == 0) begin r = '1; dz = 1'b1; end
        else r = W'(ua / ub);
      end
      4'h7: begin
        lat = W + 1;
        if (ub == 0) begin r = a; dz = 1'b1; end
        else r = W'(ua % ub);
      end
`endif
      4'h8: begin
        r = W'(s);
        o = sg ? (ss > (2**(W-1)) - 1 || ss < -(2**(W-1))) : (s >= 2**W);
      end
      4'h9: r = a | b;
      4'hA: r = a ^ b;
      4'hB: r = a & b;
      4'hC: r = W'(s >= 2**W);
      4'hD: r = W'(sg ? (sa <= sb) : (ua <= ub));
      4'hE: r = W'(sg ? (sa < sb) : (ua < ub));
      4'hF: r = W'(ua == ub);
      default: r = '0;
    endcase
  endfunction

  // Present one op (call just after a negedge), wait for its result; leaves DONE un-retired.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, b, input bit cin, sg, ia, ib);
    int wait_n;
    Op = op; A = a; B = b; Cin = cin; sign = sg; invA = ia; invB = ib;
    in_valid = 1'b1;
    wait_n = 0;
    while (!in_ready && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    @(posedge clk);
    got_lat = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      got_lat++;
      if (!out_valid && in_ready) busy_ok = 1'b0;
    end while (!out_valid && got_lat < 100);
    got_out  = Out;
    got_ofl  = Ofl;
    got_zero = zero;
    got_div0 = div0;
  endtask

  task automatic retire;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Cin = 1'b0; Op = '0; invA = 1'b0; invB = 1'b0; sign = 1'b0;
    #23;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, Out, Ofl, zero, div0} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b vld=%b Out=%h Ofl=%b zero=%b div0=%b want 1 0 0000 0 1 0",
               in_ready, out_valid, Out, Ofl, zero, div0);
    end
  endtask

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b;
    bit           cin, sg, ia, ib;
    logic [W-1:0] exp_out;
    bit           exp_ofl, exp_dz;
    int           exp_lat;
  } vec_t;

  task automatic test_directed;
    vec_t v[$];
    int   ml;
`ifdef ALU_MULDIV_EN
    ml = W + 1;
    v.push_back('{4'h5, 16'h0003, 16'h0005, 0, 0, 0, 0, 16'h000F, 0, 0, ml});
    v.push_back('{4'h6, 16'h0064, 16'h0007, 0, 0, 0, 0, 16'h000E, 0, 0, ml});
    v.push_back('{4'h7, 16'h0064, 16'h0007, 0, 0, 0, 0, 16'h0002, 0, 0, ml});
    v.push_back('{4'h6, 16'h0055, 16'h0000, 0, 0, 0, 0, 16'hFFFF, 0, 1, ml});
    v.push_back('{4'h7, 16'h0055, 16'h0000, 0, 0, 0, 0, 16'h0055, 0, 1, ml});
`else
    ml = 1;
    v.push_back('{4'h5, 16'h0003, 16'h0005, 0, 0, 0, 0, 16'h0000, 0, 0, ml});
    v.push_back('{4'h6, 16'h0064, 16'h0007, 0, 0, 0, 0, 16'h0000, 0, 0, ml});
    v.push_back('{4'h7, 16'h0055, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, ml});
`endif
    v.push_back('{4'h8, 16'h7FFF, 16'h0001, 0, 1, 0, 0, 16'h8000, 1, 0, 1});
    v.push_back('{4'h8, 16'h7FFF, 16'h0001, 0, 0, 0, 0, 16'h8000, 0, 0, 1});
    v.push_back('{4'h8, 16'hFFFF, 16'h0000, 1, 0, 0, 0, 16'h0000, 1, 0, 1});
    v.push_back('{4'hE, 16'hFFFF, 16'h0001, 0, 1, 0, 0, 16'h0001, 0, 0, 1});
    v.push_back('{4'hE, 16'hFFFF, 16'h0001, 0, 0, 0, 0, 16'h0000, 0, 0, 1});
    v.push_back('{4'hF, 16'h1234, 16'h1234, 0, 0, 0, 0, 16'h0001, 0, 0, 1});
    v.push_back('{4'hB, 16'hFF0F, 16'h00F0, 0, 0, 0, 1, 16'hFF0F, 0, 0, 1});
    v.push_back('{4'h1, 16'h0001, 16'h0004, 0, 0, 0, 0, 16'h1000, 0, 0, 1});
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, v[i].cin, v[i].sg, v[i].ia, v[i].ib);
      checks++;
      if ({got_out, got_ofl, got_div0, got_zero} !==
          {v[i].exp_out, v[i].exp_ofl, v[i].exp_dz, v[i].exp_out == '0}) begin
        errors++;
        $display("FAIL directed[%0d] op=%h: got Out=%h Ofl=%b div0=%b zero=%b want Out=%h Ofl=%b div0=%b",
                 i, v[i].op, got_out, got_ofl, got_div0, got_zero, v[i].exp_out, v[i].exp_ofl, v[i].exp_dz);
      end
      checks++;
      if (got_lat !== v[i].exp_lat) begin
        errors++;
        $display("FAIL directed_latency[%0d] op=%h: got %0d want %0d", i, v[i].op, got_lat, v[i].exp_lat);
      end
      retire();
    end
  endtask

  task automatic test_mul_busy;
    logic [W-1:0] exp_out;
    bit           o, dz;
    int           lat, n;
    bit           rdy_low;
    model(4'h5, 16'h0003, 16'h0005, 0, 0, 0, 0, exp_out, o, dz, lat);
    Op = 4'h5; A = 16'h0003; B = 16'h0005; Cin = 1'b0; sign = 1'b0; invA = 1'b0; invB = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    n = 0;
    rdy_low = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (!out_valid) begin
        if (in_ready) rdy_low = 1'b0;
        Op = 4'h8; A = 16'h1111; B = 16'h1111;
      end
    end while (!out_valid && n < 100);
    in_valid = 1'b0;
    checks++;
    if (rdy_low !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_ready: in_ready seen high during BUSY, want 0");
    end
    checks++;
    if (n !== lat || Out !== exp_out) begin
      errors++;
      $display("FAIL mul_busy: got Out=%h after %0d cycles want Out=%h after %0d", Out, n, exp_out, lat);
    end
    retire();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignored: got out_valid=%b after retire want 0", out_valid);
    end
  endtask

  task automatic test_backpressure;
    run_op(4'hA, 16'hF0F0, 16'h0FF0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || Out !== 16'hFF00) begin
        errors++;
        $display("FAIL hold[%0d]: got vld=%b Out=%h want 1 FF00", i, out_valid, Out);
      end
    end
    Op = 4'h3; A = 16'h8000; B = 16'h0004; Cin = 1'b0; sign = 1'b0; invA = 1'b0; invB = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: got in_ready=%b want 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || Out !== 16'hF800) begin
      errors++;
      $display("FAIL b2b_result: got vld=%b Out=%h want 1 F800", out_valid, Out);
    end
    retire();
  endtask

  task automatic test_reset_mid;
    Op = 4'h6; A = 16'h0064; B = 16'h0007; Cin = 1'b0; sign = 1'b0; invA = 1'b0; invB = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, Out, zero} !== {1'b0, 16'h0000, 1'b1}) begin
      errors++;
      $display("FAIL mid_reset: got vld=%b Out=%h zero=%b want 0 0000 1", out_valid, Out, zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_ready: got in_ready=%b want 1", in_ready);
    end
    @(negedge clk);
    run_op(4'h0, 16'h8001, 16'h0001, 0, 0, 0, 0);
    checks++;
    if (got_out !== 16'h0003 || got_lat !== 1) begin
      errors++;
      $display("FAIL rol_after_reset: got Out=%h lat=%0d want 0003 lat=1", got_out, got_lat);
    end
    retire();
  endtask

  task automatic test_random;
    logic [3:0]   op;
    logic [W-1:0] a, b, r;
    bit           cin, sg, ia, ib, o, dz;
    int           lat;
    for (int i = 0; i < 60; i++) begin
      op  = 4'($urandom_range(15, 0));
      a   = W'($urandom);
      b   = W'($urandom);
      if ($urandom_range(7, 0) == 0) b = '0;
      cin = 1'($urandom);
      sg  = 1'($urandom);
      ia  = 1'($urandom);
      ib  = 1'($urandom);
      model(op, a, b, cin, sg, ia, ib, r, o, dz, lat);
      run_op(op, a, b, cin, sg, ia, ib);
      checks++;
      if (got_out !== r) begin
        errors++;
        $display("FAIL rand_out[%0d] op=%h a=%h b=%h: got %h want %h", i, op, a, b, got_out, r);
      end
      checks++;
      if ({got_ofl, got_div0, got_zero} !== {o, dz, r == '0}) begin
        errors++;
        $display("FAIL rand_flags[%0d] op=%h: got ofl/div0/zero=%b%b%b want %b%b%b",
                 i, op, got_ofl, got_div0, got_zero, o, dz, r == '0);
      end
      checks++;
      if (got_lat !== lat || busy_ok !== 1'b1) begin
        errors++;
        $display("FAIL rand_latency[%0d] op=%h: got %0d (busy_ok=%b) want %0d", i, op, got_lat, busy_ok, lat);
      end
      retire();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mul_busy();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, handshaked successor to the datapath ALU. Single-cycle ops (shift/rotate, add, logic, set-compare) return in one registered cycle; multi-cycle ops (multiply, unsigned divide/remainder) run an iterative shift-add or restoring-division engine. Sits in the execute stage; the pipeline stalls on in_ready/out_valid instead of assuming fixed latency.

Parameters:
WIDTH, 16, operand/result width; power of two, >= 8
CNTW, $clog2(WIDTH), shift-count and iteration-counter width (derived, do not override)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation presented
in_ready  output  1  block can accept an operation
A  input  WIDTH  operand A
B  input  WIDTH  operand B
Cin  input  1  carry-in for ADD
Op  input  4  operation code
invA  input  1  use ~A in place of A
invB  input  1  use ~B in place of B
sign  input  1  1 = signed overflow and signed compares
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
Out  output  WIDTH  result
Ofl  output  1  ADD overflow (signed if sign, else carry-out); 0 for all other ops
zero  output  1  Out == 0
div0  output  1  DIVU/REMU with divisor 0

Behaviour:
- Op map: 0000 ROL, 0001 ROR, 0010 SLL, 0011 SRA, 0100 SRL, 0101 MUL, 0110 DIVU, 0111 REMU, 1000 ADD, 1001 OR, 1010 XOR, 1011 AND, 1100 SCO, 1101 SLE, 1110 SLT, 1111 SEQ.
- Operands are captured after inversion: a = invA ? ~A : A, b = invB ? ~B : B. Shift count = b[CNTW-1:0].
- Set ops (SCO/SLE/SLT/SEQ) produce a zero-extended 1-bit result in Out[0]. SCO = carry-out of a+b+Cin. SLT/SLE compare a vs b, signed when sign=1, unsigned otherwise.
- MUL = low WIDTH bits of a*b. DIVU = a/b, REMU = a%b, both unsigned.
- Divide by zero: quotient all-ones, remainder = a, div0=1.
- FSM states: IDLE, BUSY, DONE.
- IDLE: accept on in_valid&in_ready. Single-cycle op -> register result, go to DONE (out_valid the next cycle, latency 1). MUL/DIVU/REMU -> load engine, counter=0, go to BUSY.
- BUSY: one shift-add or restore step per cycle for exactly WIDTH cycles. On the last step, register the result and go to DONE. Latency = WIDTH+1 cycles from accept to out_valid.
- DONE: out_valid=1. Out/Ofl/zero/div0 are held stable until out_ready. On out_ready: if in_valid on the same cycle, accept the new op (back-to-back); else go to IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is 0 in BUSY; in_valid during BUSY is ignored, no queueing.
- Out, Ofl, zero and div0 are registered; zero is derived from the registered Out.
- Reset (async, any state incl. mid-BUSY): state=IDLE, counter=0, Out=0, Ofl=0, zero=1, div0=0, out_valid=0. Any partial result is discarded.
- Unlisted encodings: none; all 16 codes are defined.

Optional Feature:
ALU_MULDIV_EN. Defined: MUL/DIVU/REMU use the iterative engine as above. Undefined: engine not built, BUSY unreachable; codes 0101-0111 complete as single-cycle ops with Out=0, Ofl=0, div0=0, zero=1.

Test Plan:
- WIDTH=16, ADD A=7FFF B=0001 Cin=0 sign=1 -> Out=8000, Ofl=1, out_valid exactly 1 cycle after accept; same with sign=0 -> Ofl=0.
- SLT A=FFFF B=0001: sign=1 -> Out=0001; sign=0 -> Out=0000. SEQ A=B=1234 -> Out=0001, zero=0.
- MUL A=0003 B=0005 -> Out=000F after 17 cycles; in_ready=0 and in_valid ignored throughout BUSY.
- DIVU A=0064 B=0007 -> Out=000E; REMU -> Out=0002; DIVU B=0000 A=0055 -> Out=FFFF div0=1; REMU B=0 -> Out=0055 div0=1.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE -> Out stable, out_valid held. Release with in_valid (SRA A=8000 B=0004) -> accepted same cycle, next Out=F800.
- Assert rst_n low mid-DIVU -> immediate out_valid=0, Out=0, zero=1, in_ready=1 after release; ROL A=8001 B=0001 -> Out=0003.
